mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-port arbiter that lets several pipeline requestors (IF, LSU, future ports) share the single DRAM port through one grant/handshake path.
- Sits between the stage units and main memory inside the core top level.
- Adds selectable round-robin or fixed priority, per-port response routing, memory-side backpressure and a protocol-error flag.
- One transaction outstanding at a time.

Parameters:
NUM_PORTS, 2, number of requestor channels (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)
RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low reset
mem_en  in  1  global memory enable; new grants only while high
req_valid  in  NUM_PORTS  per-port request valid
req_ready  out  NUM_PORTS  per-port accept (combinational from state, mem_en, req_valid)
req_we  in  NUM_PORTS  per-port write enable (1 = store)
req_addr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data
req_be  in  NUM_PORTS*DATA_WIDTH/8  packed byte enables
resp_valid  out  NUM_PORTS  one-cycle completion pulse to the owning port
resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid
mem_req_valid  out  1  request to DRAM
mem_req_ready  in  1  DRAM accepts request
mem_we  out  1  latched write enable
mem_addr  out  ADDR_WIDTH  latched address
mem_wdata  out  DATA_WIDTH  latched write data
mem_be  out  DATA_WIDTH/8  latched byte enables
mem_resp_valid  in  1  DRAM completion (reads and writes)
mem_rdata  in  DATA_WIDTH  DRAM read data
busy  out  1  high in any state other than IDLE
err_unexpected_resp  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset==0 at a clock edge):
  - state <- IDLE, rr_ptr <- 0, owner <- 0.
  - All registered outputs <- 0: mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be, resp_valid, resp_rdata, err_unexpected_resp.
  - req_ready = 0 while reset is low.
  - Reset mid-transaction drops the transaction; no resp_valid is emitted for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If mem_en=1 and any req_valid, the winner w is selected and only req_ready[w]=1 that cycle; all other req_ready bits are 0.
  - On that edge: latch owner=w and port w's we/addr/wdata/be into the mem_* registers; set mem_req_valid=1; go to ISSUE.
  - With mem_en=0, req_ready is all 0 and the state stays IDLE.
- Winner selection:
  - RR_MODE=1: first valid port scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS. On grant, rr_ptr <- (w+1) mod NUM_PORTS.
  - RR_MODE=0: lowest-index valid port; rr_ptr is unused and held at 0.
- ISSUE: mem_req_valid and all mem_* fields stay stable until mem_req_ready=1. On that edge: mem_req_valid <- 0, go to WAIT.
- WAIT: on mem_resp_valid=1, resp_rdata <- mem_rdata (writes also capture mem_rdata), resp_valid[owner] <- 1, go to RESP.
- RESP: resp_valid is high for exactly this one cycle, then cleared; go to IDLE. req_ready is 0 in RESP.
- Minimum latency, with zero-wait DRAM:
  - accept at cycle T; mem_req_valid high at T+1;
  - mem_req_ready at T+1 and mem_resp_valid at T+2 give resp_valid at T+3;
  - next accept possible at T+4.
- Boundary conditions:
  - mem_en falling after acceptance does not abort; the transaction completes.
  - mem_resp_valid while in IDLE, ISSUE or RESP is ignored for data and sets err_unexpected_resp=1; the flag clears only on reset.
  - mem_resp_valid and mem_req_ready both high in ISSUE: the request is accepted, the response is flagged as unexpected, and the state still moves to WAIT.
  - A requestor may drop req_valid before it is granted without any effect.
  - Non-granted ports hold their requests and see req_ready=0.
  - rr_ptr wraps from NUM_PORTS-1 to 0.
  - Arithmetic: rr_ptr is $clog2(NUM_PORTS) bits wide; wrap is an explicit compare, never implicit overflow (NUM_PORTS need not be a power of 2).

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_valid=2'b11 -> all outputs 0, req_ready=0, busy=0; release -> port0 granted first (rr_ptr=0).
- Single read: port1 reads addr 0x80 and DRAM returns 0xDEADBEEF one cycle after mem_req_ready -> mem_addr=0x80, mem_we=0, resp_valid=2'b10 pulses at T+3 with resp_rdata=0xDEADBEEF.
- Round robin (NUM_PORTS=3, RR_MODE=1): all three ports request continuously -> grant order 0,1,2,0,1,2; no port waits more than 2 grants.
- Fixed priority (RR_MODE=0): ports 0 and 1 request continuously -> port0 is granted every transaction and port1 is never granted while port0 stays valid.
- Backpressure: mem_req_ready low for 4 cycles during a store of 0x12345678 with be=4'b0011 to 0x100 -> mem_* stable all 4 cycles, single acceptance, one resp_valid pulse.
- Errors and reset: a mem_resp_valid pulse in IDLE sets err_unexpected_resp=1, which persists; reset=0 asserted during WAIT -> state IDLE, no resp_valid, flag cleared.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requestor ports, the arbiter and the single DRAM port.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits on ready, and the payload must stay stable while valid is high and ready is low.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_we;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS*BE_WIDTH-1:0]   req_be;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]           resp_rdata;

  logic                            mem_req_valid;
  logic                            mem_req_ready;
  logic                            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [BE_WIDTH-1:0]             mem_be;
  logic                            mem_resp_valid;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-port arbiter sharing one DRAM port; one transaction in flight, round-robin or
// fixed-priority selection, per-port response routing and a sticky protocol-error flag.
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_en,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy,
  output logic                 err_unexpected_resp,
  output logic [1:0]           dbg_state
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic                   mem_req_valid_q, mem_req_valid_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]          mem_be_q, mem_be_d;
  logic [NUM_PORTS-1:0]   resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;
  logic                   err_q, err_d;

  logic                   found;
  logic [PW-1:0]          win;
  logic [PW:0]            idx;
  logic [NUM_PORTS-1:0]   req_ready_c;

  // Scan starts at rr_ptr; the wrap is an explicit compare so NUM_PORTS need not be 2^n.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ((RR_MODE != 0) ? {1'b0, rr_ptr_q} : '0) + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (!found && bus.req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    owner_d         = owner_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    resp_valid_d    = '0;
    resp_rdata_d    = resp_rdata_q;
    err_d           = err_q | (bus.mem_resp_valid && (state_q != S_WAIT));
    req_ready_c     = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_en && found) begin
          req_ready_c[win] = 1'b1;
          owner_d          = win;
          mem_req_valid_d  = 1'b1;
          mem_we_d         = bus.req_we[win];
          mem_addr_d       = bus.req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d      = bus.req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
          mem_be_d         = bus.req_be[win*BW +: BW];
          state_d          = S_ISSUE;
          if (RR_MODE != 0)
            rr_ptr_d = (win == PW'(NUM_PORTS-1)) ? '0 : win + PW'(1);
        end
      end
      S_ISSUE: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          resp_rdata_d          = bus.mem_rdata;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
      resp_valid_q    <= '0;
      resp_rdata_q    <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_q         <= owner_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_be_q        <= mem_be_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      err_q           <= err_d;
    end
  end

  // Grants are suppressed while reset is held low.
  assign bus.req_ready         = reset ? req_ready_c : '0;
  assign bus.resp_valid        = resp_valid_q;
  assign bus.resp_rdata        = resp_rdata_q;
  assign bus.mem_req_valid     = mem_req_valid_q;
  assign bus.mem_we            = mem_we_q;
  assign bus.mem_addr          = mem_addr_q;
  assign bus.mem_wdata         = mem_wdata_q;
  assign bus.mem_be            = mem_be_q;
  assign busy                  = (state_q != S_IDLE);
  assign err_unexpected_resp   = err_q;
  assign dbg_state             = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and compares
// both against a transaction-level model of the arbitration and completion rules.
module tb_mem_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic            mem_en;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*BW-1:0] req_be;
  logic            mem_req_ready, mem_resp_valid;
  logic [DW-1:0]   mem_rdata;
  logic            busy_rr, err_rr, busy_fp, err_fp;
  logic [1:0]      st_rr, st_fp;

  mem_port_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_rr ();
  mem_port_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_fp ();

  assign if_rr.req_valid      = req_valid;
  assign if_rr.req_we         = req_we;
  assign if_rr.req_addr       = req_addr;
  assign if_rr.req_wdata      = req_wdata;
  assign if_rr.req_be         = req_be;
  assign if_rr.mem_req_ready  = mem_req_ready;
  assign if_rr.mem_resp_valid = mem_resp_valid;
  assign if_rr.mem_rdata      = mem_rdata;
  assign if_fp.req_valid      = req_valid;
  assign if_fp.req_we         = req_we;
  assign if_fp.req_addr       = req_addr;
  assign if_fp.req_wdata      = req_wdata;
  assign if_fp.req_be         = req_be;
  assign if_fp.mem_req_ready  = mem_req_ready;
  assign if_fp.mem_resp_valid = mem_resp_valid;
  assign if_fp.mem_rdata      = mem_rdata;

  mem_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) u_rr (
    .clock(clock), .reset(reset), .mem_en(mem_en), .bus(if_rr.slave),
    .busy(busy_rr), .err_unexpected_resp(err_rr), .dbg_state(st_rr));

  mem_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) u_fp (
    .clock(clock), .reset(reset), .mem_en(mem_en), .bus(if_fp.slave),
    .busy(busy_fp), .err_unexpected_resp(err_fp), .dbg_state(st_fp));

  // reference model: phase 0 idle, 1 request issued, 2 awaiting data, 3 response pulse
  int            m_phase = 0;
  int            m_rr    = 0;
  int            m_owner [2];
  logic          m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [BW-1:0] m_be    [2];
  logic [DW-1:0] m_rdata;
  logic          m_err;
  int            grants_rr[$];

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus knobs
  logic          cfg_reset   = 1'b0;
  bit            cfg_rand_v  = 1'b0;
  logic [N-1:0]  cfg_vpat    = '1;
  int            cfg_en_pct  = 100;
  int            cfg_rdy_pct = 100;
  int            cfg_rsp_pct = 100;
  int            cfg_unx_pct = 0;
  int            hold_lo     = 0;
  int            f_port      = -1;
  logic          f_we        = 1'b0;
  logic [AW-1:0] f_addr      = '0;
  logic [DW-1:0] f_wdata     = '0;
  logic [BW-1:0] f_be        = '0;
  bit            f_rdata_en  = 1'b0;
  logic [DW-1:0] f_rdata     = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit rr, input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i = rr ? (ptr + k) % N : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rr = 0; m_rdata = '0; m_err = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = 0; m_we[d] = 1'b0; m_addr[d] = '0; m_wdata[d] = '0; m_be[d] = '0;
    end
  endtask

  task automatic check_dut(input string nm, input int d, input logic [N-1:0] rdy,
                           input logic [N-1:0] exp_rdy, input logic [N-1:0] rv,
                           input logic [DW-1:0] rd, input logic mrv, input logic mwe,
                           input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                           input logic [BW-1:0] mbe, input logic bsy, input logic er);
    check({nm, "_req_ready"}, 64'(rdy), 64'(exp_rdy));
    check({nm, "_resp_valid"}, 64'(rv), (m_phase == 3) ? 64'(onehot(m_owner[d])) : 64'd0);
    check({nm, "_resp_rdata"}, 64'(rd), 64'(m_rdata));
    check({nm, "_mem_req_valid"}, 64'(mrv), 64'(m_phase == 1));
    check({nm, "_mem_we"}, 64'(mwe), 64'(m_we[d]));
    check({nm, "_mem_addr"}, 64'(ma), 64'(m_addr[d]));
    check({nm, "_mem_wdata"}, 64'(mwd), 64'(m_wdata[d]));
    check({nm, "_mem_be"}, 64'(mbe), 64'(m_be[d]));
    check({nm, "_busy"}, 64'(bsy), 64'(m_phase != 0));
    check({nm, "_err"}, 64'(er), 64'(m_err));
  endtask

  // scoreboard step at the falling edge: compare, then advance the model over the next rising edge
  task automatic check_and_update();
    int w[2];
    bit grant;
    logic [N-1:0] e_rdy[2];
    w[0]  = pick(1'b1, m_rr, req_valid);
    w[1]  = pick(1'b0, 0, req_valid);
    grant = reset && (m_phase == 0) && mem_en && (req_valid != '0);
    for (int d = 0; d < 2; d++) e_rdy[d] = grant ? onehot(w[d]) : '0;
    check_dut("rr", 0, if_rr.req_ready, e_rdy[0], if_rr.resp_valid, if_rr.resp_rdata,
              if_rr.mem_req_valid, if_rr.mem_we, if_rr.mem_addr, if_rr.mem_wdata,
              if_rr.mem_be, busy_rr, err_rr);
    check_dut("fp", 1, if_fp.req_ready, e_rdy[1], if_fp.resp_valid, if_fp.resp_rdata,
              if_fp.mem_req_valid, if_fp.mem_we, if_fp.mem_addr, if_fp.mem_wdata,
              if_fp.mem_be, busy_fp, err_fp);
    if (!reset) begin
      model_reset();
    end else begin
      if (mem_resp_valid && m_phase != 2) m_err = 1'b1;
      case (m_phase)
        0: if (grant) begin
          for (int d = 0; d < 2; d++) begin
            m_owner[d] = w[d];
            m_we[d]    = req_we[w[d]];
            m_addr[d]  = req_addr[w[d]*AW +: AW];
            m_wdata[d] = req_wdata[w[d]*DW +: DW];
            m_be[d]    = req_be[w[d]*BW +: BW];
          end
          grants_rr.push_back(w[0]);
          m_rr    = (w[0] + 1) % N;
          m_phase = 1;
        end
        1: if (mem_req_ready) m_phase = 2;
        2: if (mem_resp_valid) begin m_rdata = mem_rdata; m_phase = 3; end
        default: m_phase = 0;
      endcase
    end
  endtask

  // driver
  task automatic apply_inputs();
    reset     = cfg_reset;
    req_valid = cfg_rand_v ? N'($urandom) : cfg_vpat;
    for (int i = 0; i < N; i++) begin
      req_we[i]             = 1'($urandom_range(0, 1));
      req_addr[i*AW +: AW]  = $urandom;
      req_wdata[i*DW +: DW] = $urandom;
      req_be[i*BW +: BW]    = BW'($urandom);
    end
    if (f_port >= 0) begin
      req_we[f_port]             = f_we;
      req_addr[f_port*AW +: AW]  = f_addr;
      req_wdata[f_port*DW +: DW] = f_wdata;
      req_be[f_port*BW +: BW]    = f_be;
    end
    mem_en = ($urandom_range(0, 99) < cfg_en_pct);
    if (m_phase == 1 && hold_lo > 0) begin
      mem_req_ready = 1'b0;
      hold_lo--;
    end else begin
      mem_req_ready = ($urandom_range(0, 99) < cfg_rdy_pct);
    end
    if (m_phase == 2) mem_resp_valid = ($urandom_range(0, 99) < cfg_rsp_pct);
    else              mem_resp_valid = ($urandom_range(0, 99) < cfg_unx_pct);
    mem_rdata = f_rdata_en ? f_rdata : $urandom;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      apply_inputs();
      @(negedge clock);
      check_and_update();
    end
  endtask

  task automatic wait_idle();
    int budget = 50;
    cfg_vpat = '0; cfg_rand_v = 1'b0; cfg_rdy_pct = 100; cfg_rsp_pct = 100; cfg_unx_pct = 0;
    while (m_phase != 0 && budget > 0) begin run(1); budget--; end
    if (m_phase != 0) check("wait_idle_timeout", 64'(m_phase), 64'd0);
  endtask

  initial begin
    model_reset();
    apply_inputs();
    // reset held with all ports requesting
    run(3);
    // release: continuous requests from every port
    cfg_reset = 1'b1;
    run(14);
    check("rr_first_grant", 64'(grants_rr[0]), 64'd0);
    for (int i = 1; i < grants_rr.size(); i++)
      check("rr_order", 64'(grants_rr[i]), 64'((grants_rr[i-1] + 1) % N));
    // single read on port 1 to 0x80 returning 0xDEADBEEF
    wait_idle();
    f_port = 1; f_we = 1'b0; f_addr = 32'h80; f_rdata_en = 1'b1; f_rdata = 32'hDEADBEEF;
    cfg_vpat = 3'b010;
    run(1);
    cfg_vpat = '0;
    run(5);
    check("read_rdata_rr", 64'(if_rr.resp_rdata), 64'h0DEADBEEF);
    // store with four cycles of memory backpressure
    f_port = 0; f_we = 1'b1; f_addr = 32'h100; f_wdata = 32'h12345678; f_be = 4'b0011;
    f_rdata_en = 1'b0; hold_lo = 4; cfg_vpat = 3'b001;
    run(1);
    cfg_vpat = '0;
    run(10);
    check("store_addr_fp", 64'(if_fp.mem_addr), 64'h100);
    f_port = -1;
    // randomized traffic with mem_en toggling and memory stalls
    cfg_rand_v = 1'b1; cfg_en_pct = 75; cfg_rdy_pct = 60; cfg_rsp_pct = 50;
    run(400);
    // stray response while idle sets the sticky error flag
    wait_idle();
    cfg_unx_pct = 100;
    run(1);
    cfg_unx_pct = 0;
    run(3);
    check("err_sticky_rr", 64'(err_rr), 64'd1);
    // reset while waiting for data drops the transaction and clears the flag
    cfg_vpat = 3'b111; cfg_rsp_pct = 0;
    for (int i = 0; i < 20 && m_phase != 2; i++) run(1);
    check("reached_wait", 64'(m_phase), 64'd2);
    cfg_reset = 1'b0;
    run(1);
    cfg_reset = 1'b1; cfg_vpat = '0; cfg_rsp_pct = 100;
    run(4);
    check("err_cleared_fp", 64'(err_fp), 64'd0);
    // random traffic again, with occasional stray responses
    cfg_rand_v = 1'b1; cfg_rdy_pct = 50; cfg_rsp_pct = 50; cfg_unx_pct = 5;
    run(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
